// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared mode encoding and display constants for the counter controller
package display_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } mode_e;

  // Two-digit "00" in decoder bit order: units [0:6], tens [7:13], active-low
  localparam logic [0:13] SEG_00 = 14'b0000001_0000001;

endpackage

// File: rtl/BCD_Decoder.sv
// rtl/BCD_Decoder.sv - binary 0..15 to two-digit active-low seven-segment code
module BCD_Decoder (
  input  logic [3:0]  bin,
  output logic [0:13] seg
);

  logic       tens;
  logic [3:0] units;

  function automatic logic [0:6] digit(input logic [3:0] d);
    case (d)
      4'd0:    digit = 7'b0000001;
      4'd1:    digit = 7'b1001111;
      4'd2:    digit = 7'b0010010;
      4'd3:    digit = 7'b0000110;
      4'd4:    digit = 7'b1001100;
      4'd5:    digit = 7'b0100100;
      4'd6:    digit = 7'b0100000;
      4'd7:    digit = 7'b0001111;
      4'd8:    digit = 7'b0000000;
      4'd9:    digit = 7'b0000100;
      default: digit = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tens  = (bin > 4'd9);
    units = tens ? (bin - 4'd10) : bin;
    seg   = {digit(units), digit({3'b000, tens})};
  end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer, debouncer and single-cycle press pulse for one button
module button_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          armed;
  logic          differ;
  logic [CW-1:0] cnt;

  // Until a full debounced release is seen, the counter qualifies high samples
  // instead, so a button held through reset cannot fire a press.
  assign differ = armed ? (sync2 != stable) : sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        if (armed) begin
          stable <= sync2;
          press  <= stable;
        end else begin
          armed <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/display_counter_ctrl.sv
// rtl/display_counter_ctrl.sv - 4-bit up/down counter with manual/auto modes and two-digit display
module display_counter_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int TICK_DIV     = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_inc_n,
  input  logic        btn_dec_n,
  input  logic        btn_mode_n,
  input  logic        load,
  input  logic [3:0]  sw_value,
  output logic [3:0]  count,
  output logic [0:13] seg_out,
  output logic [1:0]  mode,
  output logic        wrap
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0]    ST_MANUAL  = MANUAL;
  localparam logic [1:0]    ST_UP      = AUTO_UP;
  localparam logic [1:0]    ST_DOWN    = AUTO_DOWN;

  logic          inc_ev;
  logic          dec_ev;
  logic          mode_ev;
  logic [PW-1:0] presc;
  logic          is_auto;
  logic          tick;
  logic [1:0]    mode_nxt;
  logic [0:13]   seg_code;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_inc_n), .press(inc_ev)
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_dec_n), .press(dec_ev)
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_mode_n), .press(mode_ev)
  );

  BCD_Decoder u_bcd (
    .bin(count),
    .seg(seg_code)
  );

  assign is_auto = (mode == ST_UP) || (mode == ST_DOWN);
  assign tick    = is_auto && (presc == PRESC_LAST);

  always_comb begin
    mode_nxt = mode;
    case (mode)
      ST_MANUAL: if (mode_ev) mode_nxt = ST_UP;
      ST_UP:     if (mode_ev) mode_nxt = ST_DOWN;
      ST_DOWN:   if (mode_ev) mode_nxt = ST_MANUAL;
      default:   mode_nxt = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= ST_MANUAL;
      presc <= '0;
    end else begin
      mode <= mode_nxt;
      if ((mode_nxt != mode) || load || !is_auto || tick) presc <= '0;
      else                                                presc <= presc + PW'(1);
    end
  end

  // Priority load > manual events > tick; a losing request is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= sw_value;
      end else if (inc_ev || dec_ev) begin
        if (inc_ev && !dec_ev) begin
          count <= count + 4'd1;
          wrap  <= (count == 4'd15);
        end else if (dec_ev && !inc_ev) begin
          count <= count - 4'd1;
          wrap  <= (count == 4'd0);
        end
      end else if (tick) begin
        if (mode == ST_UP) begin
          count <= count + 4'd1;
          wrap  <= (count == 4'd15);
        end else begin
          count <= count - 4'd1;
          wrap  <= (count == 4'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_out <= SEG_00;
    else        seg_out <= seg_code;
  end

endmodule

// File: tb/tb_display_counter_ctrl.sv
// tb/tb_display_counter_ctrl.sv - scoreboard bench for display_counter_ctrl
module tb_display_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_inc_n = 1'b1;
  logic        btn_dec_n = 1'b1;
  logic        btn_mode_n = 1'b1;
  logic        load = 1'b0;
  logic [3:0]  sw_value = 4'd0;
  logic [3:0]  count;
  logic [0:13] seg_out;
  logic [1:0]  mode;
  logic        wrap;

  localparam logic [0:13] SEG_ZERO  = 14'b0000001_0000001;
  localparam logic [0:13] SEG_THREE = 14'b0000110_0000001;

  typedef struct {
    logic [3:0] c;
    logic [1:0] m;
    logic       w;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  display_counter_ctrl #(.DEBOUNCE_CYC(4), .TICK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .btn_mode_n(btn_mode_n), .load(load), .sw_value(sw_value),
    .count(count), .seg_out(seg_out), .mode(mode), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [0:13] seg_of(input logic [3:0] v);
    logic [0:6] tab [0:9];
    logic [3:0] u;
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    if (v > 4'd9) begin
      u = v - 4'd10;
      return {tab[u], tab[1]};
    end
    return {tab[v], tab[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [1:0] m, input logic w, input int g);
    exp_t e;
    e.c = c; e.m = m; e.w = w; e.gap = g;
    q.push_back(e);
  endtask

  task automatic press(input logic i, input logic d, input logic mo, input int rel);
    btn_inc_n = ~i; btn_dec_n = ~d; btn_mode_n = ~mo;
    repeat (10) @(negedge clk);
    btn_inc_n = 1'b1; btn_dec_n = 1'b1; btn_mode_n = 1'b1;
    repeat (rel) @(negedge clk);
  endtask

  task automatic load_val(input logic [3:0] v);
    load = 1'b1; sw_value = v;
    repeat (2) @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input logic [3:0] c, input logic [1:0] m, input string name);
    int n;
    n = 0;
    while (!(count === c && mode === m) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL %s: timeout, got count=%0d mode=%0d expected count=%0d mode=%0d",
               name, count, mode, c, m);
    end
  endtask

  // Monitor: an output event is any change of count/mode or a wrap pulse
  initial begin : monitor
    logic [3:0] pc;
    logic [3:0] lc;
    logic [1:0] lm;
    int         last;
    exp_t       e;
    pc = 4'd0; lc = 4'd0; lm = 2'd0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pc = 4'd0; lc = 4'd0; lm = 2'd0;
        continue;
      end
      check("seg_latency", 32'(seg_out), 32'(seg_of(pc)));
      if (count !== lc || mode !== lm || wrap === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got count=%0d mode=%0d wrap=%0b expected none",
                   count, mode, wrap);
        end else begin
          e = q.pop_front();
          check("ev_count", 32'(count), 32'(e.c));
          check("ev_mode", 32'(mode), 32'(e.m));
          check("ev_wrap", 32'(wrap), 32'(e.w));
          if (e.gap >= 0) check("ev_gap", 32'(cyc - last), 32'(e.gap));
        end
        last = cyc;
      end
      pc = count; lc = count; lm = mode;
    end
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_seg", 32'(seg_out), 32'(SEG_ZERO));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int k = 1; k <= 3; k++) begin
      push(4'(k), 2'd0, 1'b0, -1);
      press(1'b1, 1'b0, 1'b0, 10);
    end
    check("seg_three", 32'(seg_out), 32'(SEG_THREE));

    push(4'd4, 2'd0, 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      btn_inc_n = 1'b0; repeat (2) @(negedge clk);
      btn_inc_n = 1'b1; repeat (2) @(negedge clk);
    end
    press(1'b1, 1'b0, 1'b0, 10);

    push(4'd15, 2'd0, 1'b0, -1);
    load_val(4'd15);
    push(4'd0, 2'd0, 1'b1, -1);
    press(1'b1, 1'b0, 1'b0, 10);
    push(4'd15, 2'd0, 1'b1, -1);
    press(1'b0, 1'b1, 1'b0, 10);

    push(4'd7, 2'd0, 1'b0, -1);
    load_val(4'd7);
    press(1'b1, 1'b1, 1'b0, 10);
    check("incdec_same", 32'(count), 32'd7);

    push(4'd14, 2'd0, 1'b0, -1);
    load_val(4'd14);
    push(4'd14, 2'd1, 1'b0, -1);
    push(4'd15, 2'd1, 1'b0, 8);
    push(4'd0, 2'd1, 1'b1, 8);
    press(1'b0, 1'b0, 1'b1, 0);
    wait_until(4'd0, 2'd1, "auto_up_wrap");
    push(4'd0, 2'd2, 1'b0, -1);
    push(4'd15, 2'd2, 1'b1, 8);
    press(1'b0, 1'b0, 1'b1, 0);
    wait_until(4'd15, 2'd2, "auto_down_wrap");
    push(4'd15, 2'd0, 1'b0, -1);
    press(1'b0, 1'b0, 1'b1, 10);

    push(4'd3, 2'd0, 1'b0, -1);
    load_val(4'd3);
    push(4'd3, 2'd1, 1'b0, -1);
    btn_mode_n = 1'b0;
    wait_until(4'd3, 2'd1, "enter_auto_up");
    btn_mode_n = 1'b1;
    repeat (7) @(negedge clk);
    push(4'd8, 2'd1, 1'b0, 8);
    push(4'd9, 2'd1, 1'b0, 8);
    load = 1'b1; sw_value = 4'd8;
    @(negedge clk);
    load = 1'b0;
    wait_until(4'd9, 2'd1, "load_beats_tick");

    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    btn_inc_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    check("async_rst_seg", 32'(seg_out), 32'(SEG_ZERO));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("held_thru_reset", 32'(count), 32'd0);
    btn_inc_n = 1'b1;
    repeat (10) @(negedge clk);
    push(4'd1, 2'd0, 1'b0, -1);
    press(1'b1, 1'b0, 1'b0, 10);
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_counter_ctrl.md
DISPLAY_COUNTER_CTRL -- requirements
Module: display_counter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500_000, stable-level cycles required before a button is accepted (10 ms at 50 MHz).
REQ-002 Parameter TICK_DIV, default 50_000_000, clock cycles per auto-count step (1 s at 50 MHz).
REQ-003 Port clk  input  1  single system clock; every register is rising-edge triggered.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port btn_inc_n  input  1  raw pushbutton, active-low, asynchronous to clk; increment request.
REQ-006 Port btn_dec_n  input  1  raw pushbutton, active-low, asynchronous; decrement request.
REQ-007 Port btn_mode_n  input  1  raw pushbutton, active-low, asynchronous; mode-cycle request.
REQ-008 Port load  input  1  synchronous level; loads sw_value while high.
REQ-009 Port sw_value  input  4  switch value for load.
REQ-010 Port count  output  4  registered current value, 0..15.
REQ-011 Port seg_out  output  14, indexed [0:13]  registered two-digit display code in the same bit order and encoding as the existing BCD_Decoder output (units in [0:6], tens in [7:13], active-low segments).
REQ-012 Port mode  output  2  current FSM state encoding.
REQ-013 Port wrap  output  1  one-cycle pulse on wrap-around.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYC consecutive equal samples.
REQ-015 Each accepted high-to-low (press) transition SHALL produce exactly one single-cycle event; holding the button SHALL NOT repeat the event; release produces no event.
REQ-016 FSM states MANUAL(0), AUTO_UP(1), AUTO_DOWN(2); a mode event cycles MANUAL->AUTO_UP->AUTO_DOWN->MANUAL; encoding 3 is unreachable and SHALL recover to MANUAL on the next clock.
REQ-017 A prescaler SHALL count 0..TICK_DIV-1 only in AUTO states and emit a tick on its terminal value; it clears on entering any state and on load.
REQ-018 Count update priority per cycle: load > manual (inc/dec event) > auto tick; a lower-priority request in the same cycle SHALL be dropped, not deferred.
REQ-019 load high: count <= sw_value; no wrap pulse.
REQ-020 inc event alone: count+1; dec event alone: count-1; inc and dec events in the same cycle: count unchanged, no wrap.
REQ-021 Tick: AUTO_UP adds 1, AUTO_DOWN subtracts 1.
REQ-022 Arithmetic is modulo 16; 15+1 -> 0 and 0-1 -> 15 SHALL each assert wrap for exactly the following clock cycle (registered with the count update).
REQ-023 Manual inc/dec events SHALL be honoured in every state.
REQ-024 A mode event in the same cycle as a count update SHALL apply both.
REQ-025 seg_out SHALL equal the BCD_Decoder encoding of count, registered one cycle after count changes (latency 1 from count).

Reset
REQ-026 rst_n low SHALL immediately force count=0, mode=MANUAL, wrap=0, prescaler=0, synchronizer/debouncer state = released (high), seg_out = display "00" (0000001 in both digits).
REQ-027 Reset asserted mid-debounce or mid-prescale SHALL discard partial progress; a button held through reset deassertion SHALL NOT generate an event until released and re-pressed.

Structure
REQ-028 Shared package display_pkg SHALL hold the mode enum (MANUAL, AUTO_UP, AUTO_DOWN) and the seg code constant for "00".
REQ-029 Sub-module button_debounce (synchronizer + debouncer + press-edge pulse, parameter DEBOUNCE_CYC) SHALL be instantiated three times; BCD_Decoder SHALL be instantiated unmodified for segment encoding.

Verification (DEBOUNCE_CYC=4, TICK_DIV=8)
REQ-030 Release reset, press btn_inc_n 3 times (each held 10 cycles) -> count 1,2,3; seg_out units "3" (0000110), tens "0"; one event per press.
REQ-031 Bounce btn_inc_n low/high every 2 cycles for 20 cycles, then hold low -> exactly one increment.
REQ-032 load=1, sw_value=15, then one inc press -> count 0, wrap high for 1 cycle; dec press -> count 15, wrap pulse.
REQ-033 Mode press once (AUTO_UP), count=14 -> count 15 after 8 cycles, 0 after 16 with wrap; mode press again (AUTO_DOWN) -> 0 then 15 after 8.
REQ-034 Inc and dec events in the same cycle at count=7 -> count stays 7; load with simultaneous tick -> sw_value wins.
REQ-035 Assert rst_n low mid-AUTO_UP at count=9 -> count 0, mode MANUAL, seg_out "00" immediately, asynchronously to clk.
